inst_dispatch_queue: RTL
========================

// Module: inst_dispatch_queue
// PURPOSE
//  Upstream instruction source for SYSTOLIC_ARRAY: buffers host-written instructions in a FIFO and drives
//  the array's instruction bus. Advances one instruction per array consume event (flag 1->0).
//  Fills gaps with the IDLE instruction when the queue is empty or issue is paused.
// PARAMETERS
//  INST_BITS    32  instruction width (matches SYSTOLIC_ARRAY INST_BITS)
//  OPCODE_BITS  4   opcode field width, occupies instruction[INST_BITS-1 -: OPCODE_BITS]
//  IDLE_OPCODE  0   opcode of IDLE_INST; filler word = {IDLE_OPCODE, zeros}
//  DEPTH        16  FIFO entries, power of two >= 2
//  CNT_BITS     16  width of issued-instruction counter
// PORTS
//  clk          in   1                clock
//  reset_n      in   1                reset (synchronous, active-low)
//  wr_en        in   1                host push request
//  wr_inst      in   INST_BITS        instruction to enqueue
//  run          in   1                1 = issue from queue; 0 = present IDLE after current consume
//  full         out  1                queue holds DEPTH entries
//  empty        out  1                queue holds 0 entries
//  level        out  $clog2(DEPTH)+1  current occupancy
//  overflow     out  1                sticky: push attempted while full and no pop in that cycle
//  issued_cnt   out  CNT_BITS         count of non-IDLE instructions consumed by the array
//  instruction  out  INST_BITS        instruction bus to SYSTOLIC_ARRAY (registered)
//  flag         in   1                array handshake; consume event = flag 1 in previous cycle, 0 now
//  idle_flag    in   1                array idle status; used for busy only
//  busy         out  1                !empty | (state==S_ISSUE) | !idle_flag
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge):
//    FIFO pointers/level=0, state=S_FILL, instruction=IDLE word, overflow=0, issued_cnt=0, flag_q=0.
//    Reset mid-operation discards queued entries; any in-flight array op is not aborted.
//  - consume = flag_q & ~flag; flag_q registers flag every cycle.
//  - States:
//    S_FILL (instruction = IDLE word); S_ISSUE (instruction = entry popped last).
//  - On consume (all next-state decisions made only here; instruction is held stable otherwise):
//      if run & !empty: pop head -> instruction register, state=S_ISSUE;
//                       issued_cnt += 1 if prior state S_ISSUE
//      else: instruction=IDLE word, state=S_FILL; issued_cnt += 1 if prior state S_ISSUE
//    New instruction visible the cycle after the consume cycle (1-cycle latency).
//  - No consume: state and instruction unchanged.
//    An empty queue never changes instruction except via consume.
//  - Push: accepted if !full, or if full and a pop occurs in the same cycle (simultaneous push+pop keeps level).
//    Rejected push: data dropped, overflow<=1 until reset.
//  - Push into empty queue with same-cycle consume: not popped this cycle (no bypass); popped at next consume.
//  - Pointers wrap modulo DEPTH; level saturates neither way (guarded by full/empty).
//  - issued_cnt wraps at 2^CNT_BITS.
//    A queued word whose opcode equals IDLE_OPCODE is issued and counted like any other.
//  - full/empty/level are combinational from registered pointers/level.
//  - run deassert does not recall the currently presented instruction; it takes effect at the next consume.
// TESTING
//  1 Reset: hold reset_n=0 2 cycles with wr_en=1
//    -> level=0, empty=1, instruction opcode=IDLE_OPCODE, overflow=0, issued_cnt=0.
//  2 Push 3 instrs A,B,C, run=1, pulse flag 1->0 four times
//    -> instruction A,B,C,IDLE each 1 cycle after consume; issued_cnt=3; empty=1.
//  3 Push DEPTH+1 with no consume -> full=1, level=DEPTH, overflow=1; 17th entry absent from issue order.
//  4 Full queue, wr_en=1 in same cycle as consume
//    -> level stays DEPTH, overflow stays 0, new word issued last (wrap check).
//  5 run=0 with 2 queued, 3 consumes -> instruction stays IDLE, level=2;
//    run=1, next consume -> first queued word.
//  6 Assert reset_n=0 mid-stream with 5 queued -> empty=1, instruction=IDLE next cycle;
//    subsequent consume keeps IDLE.

Source files
------------

// File: rtl/inst_dispatch_queue.sv
// inst_dispatch_queue: host-fed instruction FIFO that drives the systolic
// array instruction bus. One queued instruction is presented per array
// consume event (flag falling edge); the IDLE word fills any gap.
module inst_dispatch_queue #(
  parameter int INST_BITS   = 32,
  parameter int OPCODE_BITS = 4,
  parameter int IDLE_OPCODE = 0,
  parameter int DEPTH       = 16,
  parameter int CNT_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [INST_BITS-1:0]     wr_inst,
  input  logic                     run,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_BITS-1:0]      issued_cnt,
  output logic [INST_BITS-1:0]     instruction,
  input  logic                     flag,
  input  logic                     idle_flag,
  output logic                     busy
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int LVL_BITS = PTR_BITS + 1;
  localparam logic [OPCODE_BITS-1:0] IDLE_OP   = OPCODE_BITS'(IDLE_OPCODE);
  localparam logic [INST_BITS-1:0]   IDLE_WORD = {IDLE_OP, {(INST_BITS-OPCODE_BITS){1'b0}}};
  localparam logic [LVL_BITS-1:0]    DEPTH_LVL = LVL_BITS'(DEPTH);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  state_e                 state_q;
  logic [INST_BITS-1:0]   mem_q [DEPTH];
  logic [PTR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LVL_BITS-1:0]    level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic                   flag_q;
  logic [CNT_BITS-1:0]    cnt_q;
  logic [INST_BITS-1:0]   inst_q;
  logic                   consume_s, pop_s, push_s;

  // Status flags derive straight from the registered occupancy.
  assign full        = (level_q == DEPTH_LVL);
  assign empty       = (level_q == {LVL_BITS{1'b0}});
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign issued_cnt  = cnt_q;
  assign instruction = inst_q;
  assign busy        = ~empty | (state_q == S_ISSUE) | ~idle_flag;

  // Handshake decode and FIFO next-state; a full queue still accepts a push when the same cycle pops.
  always_comb begin
    consume_s  = flag_q & ~flag;
    pop_s      = consume_s & run & ~empty;
    push_s     = wr_en & (~full | pop_s);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_BITS'(1);
      2'b01:   level_d = level_q - LVL_BITS'(1);
      default: level_d = level_q;
    endcase
    if (wr_en & ~push_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO storage; stale data behind the pointers is harmless, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_inst;
    end
  end

  // Pointers, occupancy, sticky overflow and the flag history register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q   <= {PTR_BITS{1'b0}};
      wr_ptr_q   <= {PTR_BITS{1'b0}};
      level_q    <= {LVL_BITS{1'b0}};
      overflow_q <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      flag_q     <= flag;
    end
  end

  // Issue FSM: instruction bus and counter only move on a consume event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FILL;
      inst_q  <= IDLE_WORD;
      cnt_q   <= {CNT_BITS{1'b0}};
    end else if (consume_s) begin
      if (state_q == S_ISSUE) begin
        cnt_q <= cnt_q + CNT_BITS'(1);
      end
      if (pop_s) begin
        inst_q  <= mem_q[rd_ptr_q];
        state_q <= S_ISSUE;
      end else begin
        inst_q  <= IDLE_WORD;
        state_q <= S_FILL;
      end
    end
  end

endmodule
